// File: rtl/lsu_stage_if.sv
// rtl/lsu_stage_if.sv - data-memory req/ack bus between the LSU and the RAM port
interface lsu_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  o_ram_req;
  logic                  o_ram_we;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic [DATA_WIDTH-1:0] o_ram_wr_data;
  logic [3:0]            o_ram_wr_strb;
  logic                  i_ram_ack;
  logic [DATA_WIDTH-1:0] i_ram_rd_data;

  modport master (
    output o_ram_req, o_ram_we, o_ram_addr, o_ram_wr_data, o_ram_wr_strb,
    input  i_ram_ack, i_ram_rd_data
  );

  modport slave (
    input  o_ram_req, o_ram_we, o_ram_addr, o_ram_wr_data, o_ram_wr_strb,
    output i_ram_ack, i_ram_rd_data
  );
endinterface

// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - load/store stage: one data-memory access per memory op
// Loads are lane-aligned and extended here; stores get shifted data and byte strobes.
module lsu_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARGS_WIDTH = 8
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_exu_valid,
  output logic                  o_lsu_ready,
  input  logic [ADDR_WIDTH-1:0] i_exu_pc,
  input  logic [DATA_WIDTH-1:0] i_exu_res,
  input  logic [DATA_WIDTH-1:0] i_gpr_rs2_data,
  input  logic                  i_idu_ctr_ram_rd_en,
  input  logic                  i_idu_ctr_ram_wr_en,
  input  logic [ARGS_WIDTH-1:0] i_idu_ctr_ram_byt,
  input  logic [ARGS_WIDTH-1:0] i_idu_ctr_inst_type,
  lsu_stage_if.master           ram,
  output logic                  o_lsu_valid,
  input  logic                  i_wbu_ready,
  output logic [ADDR_WIDTH-1:0] o_lsu_pc,
  output logic [DATA_WIDTH-1:0] o_lsu_res,
  output logic [ARGS_WIDTH-1:0] o_lsu_inst_type,
  output logic                  o_lsu_exc
);
  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [2:0]            byt_q;
  logic [ARGS_WIDTH-1:0] type_q;

  logic                  accept;
  logic                  is_mem;
  logic                  exc;
  logic [2:0]            byt;
  logic [1:0]            lane;
  logic [3:0]            strb_next;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  unused_byt_hi;

  assign o_lsu_ready   = (state == IDLE) || (state == DONE && i_wbu_ready);
  assign accept        = i_exu_valid && o_lsu_ready;
  assign byt           = i_idu_ctr_ram_byt[2:0];
  assign lane          = i_exu_res[1:0];
  assign is_mem        = i_idu_ctr_ram_rd_en || i_idu_ctr_ram_wr_en;
  assign unused_byt_hi = ^i_idu_ctr_ram_byt[ARGS_WIDTH-1:3];

  always_comb begin
    exc = 1'b0;
    case (byt)
      3'd1, 3'd5:       exc = lane[0];
      3'd2:             exc = (lane != 2'b00);
      3'd3, 3'd6, 3'd7: exc = 1'b1;
      default:          exc = 1'b0;
    endcase
  end

  // A store wins when both rd_en and wr_en are set, so strobes key off wr_en alone.
  always_comb begin
    strb_next = 4'b0000;
    if (i_idu_ctr_ram_wr_en) begin
      case (byt[1:0])
        2'd0:    strb_next = 4'b0001 << lane;
        2'd1:    strb_next = 4'b0011 << lane;
        default: strb_next = 4'b1111;
      endcase
    end
  end

  assign rd_word = ram.i_ram_rd_data >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (byt_q)
      3'd0:    load_val = {{(DATA_WIDTH-8){rd_word[7]}}, rd_word[7:0]};
      3'd4:    load_val = {{(DATA_WIDTH-8){1'b0}}, rd_word[7:0]};
      3'd1:    load_val = {{(DATA_WIDTH-16){rd_word[15]}}, rd_word[15:0]};
      3'd5:    load_val = {{(DATA_WIDTH-16){1'b0}}, rd_word[15:0]};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state             <= IDLE;
      pc_q              <= '0;
      addr_q            <= '0;
      wr_q              <= 1'b0;
      byt_q             <= 3'd0;
      type_q            <= '0;
      ram.o_ram_req     <= 1'b0;
      ram.o_ram_we      <= 1'b0;
      ram.o_ram_addr    <= '0;
      ram.o_ram_wr_data <= '0;
      ram.o_ram_wr_strb <= 4'b0000;
      o_lsu_valid       <= 1'b0;
      o_lsu_pc          <= '0;
      o_lsu_res         <= '0;
      o_lsu_inst_type   <= '0;
      o_lsu_exc         <= 1'b0;
    end else begin
      case (state)
        MEM: begin
          if (ram.i_ram_ack) begin
            state           <= DONE;
            ram.o_ram_req   <= 1'b0;
            o_lsu_valid     <= 1'b1;
            o_lsu_pc        <= pc_q;
            o_lsu_inst_type <= type_q;
            o_lsu_exc       <= 1'b0;
            o_lsu_res       <= wr_q ? addr_q : load_val;
          end
        end
        DONE: begin
          if (i_wbu_ready) begin
            state       <= IDLE;
            o_lsu_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      // Accept overrides the DONE->IDLE retire above when both happen together.
      if (accept) begin
        pc_q   <= i_exu_pc;
        addr_q <= i_exu_res;
        wr_q   <= i_idu_ctr_ram_wr_en;
        byt_q  <= byt;
        type_q <= i_idu_ctr_inst_type;
        if (is_mem && !exc) begin
          state             <= MEM;
          o_lsu_valid       <= 1'b0;
          ram.o_ram_req     <= 1'b1;
          ram.o_ram_we      <= i_idu_ctr_ram_wr_en;
          ram.o_ram_addr    <= {i_exu_res[ADDR_WIDTH-1:2], 2'b00};
          ram.o_ram_wr_data <= i_gpr_rs2_data << {lane, 3'b000};
          ram.o_ram_wr_strb <= strb_next;
        end else begin
          state           <= DONE;
          o_lsu_valid     <= 1'b1;
          o_lsu_pc        <= i_exu_pc;
          o_lsu_inst_type <= i_idu_ctr_inst_type;
          o_lsu_exc       <= is_mem;
          o_lsu_res       <= i_exu_res;
        end
      end
    end
  end
endmodule

// File: tb/tb_lsu_stage.sv
// tb/tb_lsu_stage.sv - self-checking bench for lsu_stage
module tb_lsu_stage;
  logic        i_sys_clk = 1'b0;
  logic        i_sys_rst;
  logic        i_exu_valid;
  logic        o_lsu_ready;
  logic [31:0] i_exu_pc;
  logic [31:0] i_exu_res;
  logic [31:0] i_gpr_rs2_data;
  logic        i_idu_ctr_ram_rd_en;
  logic        i_idu_ctr_ram_wr_en;
  logic [7:0]  i_idu_ctr_ram_byt;
  logic [7:0]  i_idu_ctr_inst_type;
  logic        o_lsu_valid;
  logic        i_wbu_ready;
  logic [31:0] o_lsu_pc;
  logic [31:0] o_lsu_res;
  logic [7:0]  o_lsu_inst_type;
  logic        o_lsu_exc;

  always #5 i_sys_clk = ~i_sys_clk;

  lsu_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) rif ();

  lsu_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ARGS_WIDTH(8)) dut (
    .i_sys_clk           (i_sys_clk),
    .i_sys_rst           (i_sys_rst),
    .i_exu_valid         (i_exu_valid),
    .o_lsu_ready         (o_lsu_ready),
    .i_exu_pc            (i_exu_pc),
    .i_exu_res           (i_exu_res),
    .i_gpr_rs2_data      (i_gpr_rs2_data),
    .i_idu_ctr_ram_rd_en (i_idu_ctr_ram_rd_en),
    .i_idu_ctr_ram_wr_en (i_idu_ctr_ram_wr_en),
    .i_idu_ctr_ram_byt   (i_idu_ctr_ram_byt),
    .i_idu_ctr_inst_type (i_idu_ctr_inst_type),
    .ram                 (rif),
    .o_lsu_valid         (o_lsu_valid),
    .i_wbu_ready         (i_wbu_ready),
    .o_lsu_pc            (o_lsu_pc),
    .o_lsu_res           (o_lsu_res),
    .o_lsu_inst_type     (o_lsu_inst_type),
    .o_lsu_exc           (o_lsu_exc)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  byt;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          wt;
  } op_t;

  typedef struct {
    bit          req;
    bit          exc;
    logic [31:0] res;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          chk_res;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t exp;
  } vec_t;

  typedef struct {
    bit          req;
    bit          we;
    bit          stable;
    bit          valid;
    bit          exc;
    logic [31:0] res;
    logic [31:0] pc;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          lat;
  } got_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_exu_valid         = 1'b0;
    i_exu_pc            = '0;
    i_exu_res           = '0;
    i_gpr_rs2_data      = '0;
    i_idu_ctr_ram_rd_en = 1'b0;
    i_idu_ctr_ram_wr_en = 1'b0;
    i_idu_ctr_ram_byt   = '0;
    i_idu_ctr_inst_type = '0;
    i_wbu_ready         = 1'b1;
    rif.i_ram_ack       = 1'b0;
    rif.i_ram_rd_data   = '0;
  endtask

  // Reference: size in bytes from the low two code bits, misalignment by modulo,
  // load extension by range arithmetic.
  function automatic exp_t model(input op_t o);
    exp_t   e;
    int     bytes;
    int     off;
    longint v;
    bytes     = 1 << (o.byt % 4);
    off       = int'(o.addr % 4);
    e.req     = 0;
    e.exc     = 0;
    e.res     = o.addr;
    e.waddr   = o.addr - off;
    e.wdata   = '0;
    e.strb    = 4'b0000;
    e.chk_res = 1;
    if (!(o.rd || o.wr)) return e;
    if (o.byt == 3 || o.byt >= 6 || (off % bytes) != 0) begin
      e.exc = 1;
      return e;
    end
    e.req = 1;
    if (o.wr) begin
      e.strb    = 4'((1 << bytes) - 1) << off;
      e.wdata   = o.rs2 << (8 * off);
      e.chk_res = 0;
    end else begin
      v = longint'(o.rdata >> (8 * off)) % (longint'(1) << (8 * bytes));
      if (o.byt < 4 && bytes < 4 && v >= (longint'(1) << (8 * bytes - 1)))
        v = v - (longint'(1) << (8 * bytes));
      e.res = 32'(v);
    end
    return e;
  endfunction

  task automatic run_op(input op_t o, output got_t g);
    int nreq;
    g                   = '{default: 0};
    g.stable            = 1;
    nreq                = 0;
    i_exu_valid         = 1'b1;
    i_exu_pc            = o.addr ^ 32'hA5A5_0000;
    i_exu_res           = o.addr;
    i_gpr_rs2_data      = o.rs2;
    i_idu_ctr_ram_rd_en = o.rd;
    i_idu_ctr_ram_wr_en = o.wr;
    i_idu_ctr_ram_byt   = {5'b0, o.byt};
    i_idu_ctr_inst_type = o.addr[7:0];
    i_wbu_ready         = 1'b1;
    rif.i_ram_ack       = 1'b0;
    rif.i_ram_rd_data   = o.rdata;
    step();
    i_exu_valid = 1'b0;
    g.lat       = 1;
    while (!o_lsu_valid && g.lat < 40) begin
      if (rif.o_ram_req) begin
        if (nreq == 0) begin
          g.waddr = rif.o_ram_addr;
          g.wdata = rif.o_ram_wr_data;
          g.strb  = rif.o_ram_wr_strb;
          g.we    = rif.o_ram_we;
        end else if (g.waddr !== rif.o_ram_addr || g.wdata !== rif.o_ram_wr_data ||
                     g.strb !== rif.o_ram_wr_strb || g.we !== rif.o_ram_we) begin
          g.stable = 0;
        end
        nreq++;
        g.req         = 1;
        rif.i_ram_ack = (nreq > o.wt);
      end
      step();
      rif.i_ram_ack = 1'b0;
      g.lat++;
    end
    g.valid = o_lsu_valid;
    g.res   = o_lsu_res;
    g.exc   = o_lsu_exc;
    g.pc    = o_lsu_pc;
    step();
  endtask

  task automatic compare(input string tag, input op_t o, input exp_t e, input got_t g);
    check({tag, ".valid"}, g.valid, 1'b1);
    check({tag, ".req"}, g.req, e.req);
    check({tag, ".exc"}, g.exc, e.exc);
    check({tag, ".pc"}, g.pc, o.addr ^ 32'hA5A5_0000);
    check({tag, ".lat"}, g.lat, e.req ? 2 + o.wt : 1);
    if (e.chk_res) check({tag, ".res"}, g.res, e.res);
    if (e.req) begin
      check({tag, ".addr"}, g.waddr, e.waddr);
      check({tag, ".we"}, g.we, o.wr);
      check({tag, ".strb"}, g.strb, e.strb);
      if (o.wr) check({tag, ".wdata"}, g.wdata, e.wdata);
      check({tag, ".stable"}, g.stable, 1'b1);
    end
  endtask

  vec_t vecs[$];

  initial begin
    got_t g;
    op_t  o;

    // {rd, wr, byt, addr, rs2, rdata, wt}, {req, exc, res, waddr, wdata, strb, chk_res}
    vecs.push_back('{'{1, 0, 3'd0, 32'h1003, 32'h0, 32'h80FF_1234, 0}, '{1, 0, 32'hFFFF_FF80, 32'h1000, 32'h0, 4'h0, 1}});
    vecs.push_back('{'{1, 0, 3'd4, 32'h1003, 32'h0, 32'h80FF_1234, 0}, '{1, 0, 32'h0000_0080, 32'h1000, 32'h0, 4'h0, 1}});
    vecs.push_back('{'{0, 1, 3'd1, 32'h2002, 32'h0000_BEEF, 32'h0, 3}, '{1, 0, 32'h0, 32'h2000, 32'hBEEF_0000, 4'hC, 0}});
    vecs.push_back('{'{1, 0, 3'd2, 32'h3001, 32'h0, 32'h0, 0}, '{0, 1, 32'h3001, 32'h0, 32'h0, 4'h0, 1}});
    vecs.push_back('{'{1, 0, 3'd1, 32'h1002, 32'h0, 32'h80FF_1234, 1}, '{1, 0, 32'hFFFF_80FF, 32'h1000, 32'h0, 4'h0, 1}});
    vecs.push_back('{'{1, 0, 3'd5, 32'h1002, 32'h0, 32'h80FF_1234, 2}, '{1, 0, 32'h0000_80FF, 32'h1000, 32'h0, 4'h0, 1}});
    vecs.push_back('{'{1, 0, 3'd1, 32'h1001, 32'h0, 32'h0, 0}, '{0, 1, 32'h1001, 32'h0, 32'h0, 4'h0, 1}});
    vecs.push_back('{'{1, 0, 3'd3, 32'h1000, 32'h0, 32'h0, 0}, '{0, 1, 32'h1000, 32'h0, 32'h0, 4'h0, 1}});
    vecs.push_back('{'{0, 1, 3'd0, 32'h4001, 32'h1234_56AB, 32'h0, 0}, '{1, 0, 32'h0, 32'h4000, 32'h3456_AB00, 4'h2, 0}});
    vecs.push_back('{'{0, 1, 3'd2, 32'h5000, 32'hDEAD_BEEF, 32'h0, 1}, '{1, 0, 32'h0, 32'h5000, 32'hDEAD_BEEF, 4'hF, 0}});
    vecs.push_back('{'{1, 1, 3'd0, 32'h6003, 32'h0000_0077, 32'h0, 0}, '{1, 0, 32'h0, 32'h6000, 32'h7700_0000, 4'h8, 0}});
    vecs.push_back('{'{0, 0, 3'd2, 32'h1234_5678, 32'h0, 32'h0, 0}, '{0, 0, 32'h1234_5678, 32'h0, 32'h0, 4'h0, 1}});
    vecs.push_back('{'{1, 0, 3'd2, 32'h7000, 32'h0, 32'hCAFE_F00D, 0}, '{1, 0, 32'hCAFE_F00D, 32'h7000, 32'h0, 4'h0, 1}});
    vecs.push_back('{'{0, 1, 3'd7, 32'h7000, 32'h1, 32'h0, 0}, '{0, 1, 32'h7000, 32'h0, 32'h0, 4'h0, 1}});

    idle_inputs();
    i_sys_rst = 1'b1;
    step();
    step();
    i_sys_rst = 1'b0;
    check("rst.ready", o_lsu_ready, 1'b1);
    check("rst.valid", o_lsu_valid, 1'b0);
    check("rst.req", rif.o_ram_req, 1'b0);
    check("rst.we", rif.o_ram_we, 1'b0);
    check("rst.addr", rif.o_ram_addr, 32'h0);
    check("rst.strb", rif.o_ram_wr_strb, 4'h0);
    check("rst.res", o_lsu_res, 32'h0);
    check("rst.exc", o_lsu_exc, 1'b0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, g);
      compare($sformatf("vec%0d", i), vecs[i].op, vecs[i].exp, g);
    end

    for (int i = 0; i < 150; i++) begin
      o.rd    = 1'($urandom_range(0, 1));
      o.wr    = 1'($urandom_range(0, 1));
      o.byt   = 3'($urandom_range(0, 7));
      o.addr  = $urandom;
      if ($urandom_range(0, 1) == 1) o.addr[1:0] = 2'b00;
      o.rs2   = $urandom;
      o.rdata = $urandom;
      o.wt    = $urandom_range(0, 3);
      run_op(o, g);
      compare($sformatf("rnd%0d", i), o, model(o), g);
    end

    // Reset while a load is waiting on memory; a late ack must be ignored.
    i_exu_valid         = 1'b1;
    i_exu_res           = 32'h100;
    i_idu_ctr_ram_rd_en = 1'b1;
    i_idu_ctr_ram_wr_en = 1'b0;
    i_idu_ctr_ram_byt   = 8'd2;
    step();
    i_exu_valid = 1'b0;
    step();
    check("midrst.req_before", rif.o_ram_req, 1'b1);
    i_sys_rst = 1'b1;
    step();
    step();
    i_sys_rst = 1'b0;
    check("midrst.req", rif.o_ram_req, 1'b0);
    check("midrst.valid", o_lsu_valid, 1'b0);
    check("midrst.ready", o_lsu_ready, 1'b1);
    rif.i_ram_ack = 1'b1;
    step();
    rif.i_ram_ack = 1'b0;
    check("lateack.valid", o_lsu_valid, 1'b0);
    check("lateack.req", rif.o_ram_req, 1'b0);
    step();
    check("lateack.valid2", o_lsu_valid, 1'b0);

    // Three back-to-back ALU ops.
    idle_inputs();
    for (int k = 1; k <= 3; k++) begin
      i_exu_valid         = 1'b1;
      i_exu_res           = 32'(k);
      i_idu_ctr_inst_type = 8'(k + 16);
      step();
      check($sformatf("b2b%0d.valid", k), o_lsu_valid, 1'b1);
      check($sformatf("b2b%0d.res", k), o_lsu_res, 32'(k));
      check($sformatf("b2b%0d.type", k), o_lsu_inst_type, 8'(k + 16));
      check($sformatf("b2b%0d.ready", k), o_lsu_ready, 1'b1);
    end
    i_exu_valid = 1'b0;
    step();
    check("b2b.drain", o_lsu_valid, 1'b0);

    // WBU backpressure with a waiting upstream instruction.
    i_exu_valid = 1'b1;
    i_exu_res   = 32'h55;
    i_wbu_ready = 1'b0;
    step();
    i_exu_res = 32'h66;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall%0d.valid", k), o_lsu_valid, 1'b1);
      check($sformatf("stall%0d.res", k), o_lsu_res, 32'h55);
      check($sformatf("stall%0d.ready", k), o_lsu_ready, 1'b0);
      step();
    end
    i_wbu_ready = 1'b1;
    #1;
    check("stall.ready_rise", o_lsu_ready, 1'b1);
    step();
    i_exu_valid = 1'b0;
    check("stall.next_valid", o_lsu_valid, 1'b1);
    check("stall.next_res", o_lsu_res, 32'h66);
    step();
    check("stall.drain", o_lsu_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
